// File: rtl/reset_sequencer_if.sv
// Reset-sequencer bundle: lock inputs, software request and the staged reset outputs.
// The sequencer takes the slave modport; the clock-domain owner or a bench takes master.
interface reset_sequencer_if #(
  parameter int NUM_LOCK = 1,
  parameter int NUM_OUT  = 4
);
  logic [NUM_LOCK-1:0] lock;
  logic                sw_reset_req;
  logic [NUM_OUT-1:0]  rst_out;
  logic                rst_done;

  modport master (
    output lock,
    output sw_reset_req,
    input  rst_out,
    input  rst_done
  );

  modport slave (
    input  lock,
    input  sw_reset_req,
    output rst_out,
    output rst_done
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset bridge and staggered release sequencer for one clock domain: asynchronous
// assertion on async_reset or lock loss, synchronous hardened and staged deassertion.
module reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_LOCK    = 1,
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic             clk,
  input  logic             async_reset,
  reset_sequencer_if.slave bus
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]      GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [NUM_OUT-1:0] LAST_BIT  = NUM_OUT'(1) << (NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  logic                   arst;
  logic [SYNC_STAGES-2:0] chain;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NUM_OUT-1:0]     rst_q;
  logic                   done_q;

  // Any lock bit low is as strong as the hard reset pin.
  assign arst = async_reset | ~(&bus.lock);

  // The FSM's ASSERT state register is the last hardening stage, so the chain
  // itself is one flop shorter and leaving ASSERT coincides with T0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) chain <= '1;
    else      chain <= chain << 1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= ST_ASSERT;
      cnt    <= '0;
      rst_q  <= '1;
      done_q <= 1'b0;
    end else if (state == ST_ASSERT) begin
      if (!chain[SYNC_STAGES-2]) begin
        state <= ST_HOLD;
        cnt   <= '0;
      end
    end else if (bus.sw_reset_req) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      rst_q  <= '1;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_HOLD, ST_RELEASE: begin
          if (cnt == ((state == ST_HOLD) ? HOLD_LAST : GAP_LAST)) begin
            // Shifting left releases bit 0 first and keeps released bits low.
            rst_q  <= rst_q << 1;
            cnt    <= '0;
            state  <= (rst_q == LAST_BIT) ? ST_DONE : ST_RELEASE;
            done_q <= (rst_q == LAST_BIT);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rst_out  = rst_q;
  assign bus.rst_done = done_q;

endmodule
